// File: rtl/moving_avg_window_if.sv
// ----------------------------------------------------------------------------
// moving_avg_window_if
//
// Sample/result bundle between a sample producer and the moving-average
// window.
//
//   sample_ready : strobe, sample is valid this cycle     (producer -> averager)
//   sample       : unsigned sample                        (producer -> averager)
//   avg          : registered window average              (averager -> consumer)
//   avg_valid    : one-cycle pulse when avg updates       (averager -> consumer)
//   busy         : averager is not idle                   (averager -> producer)
//   overrun      : pulse, a strobe was dropped last cycle (averager -> producer)
//
// Modports: master = producer/consumer side, slave = averager side.
// ----------------------------------------------------------------------------
interface moving_avg_window_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  sample_ready;
    logic [DATA_WIDTH-1:0] sample;
    logic [DATA_WIDTH-1:0] avg;
    logic                  avg_valid;
    logic                  busy;
    logic                  overrun;

    modport master (
        output sample_ready,
        output sample,
        input  avg,
        input  avg_valid,
        input  busy,
        input  overrun
    );

    modport slave (
        input  sample_ready,
        input  sample,
        output avg,
        output avg_valid,
        output busy,
        output overrun
    );
endinterface

// File: rtl/moving_avg_window.sv
// ----------------------------------------------------------------------------
// moving_avg_window
//
// Sliding-window averager over the last 2^LOG2_DEPTH unsigned samples. A
// circular buffer plus running sum give the window total; while the window
// is filling the total is divided by the true sample count with a sequential
// restoring divider (one quotient bit per cycle), once full by a shift.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : moving_avg_window_if.slave (sample_ready, sample in;
//          avg, avg_valid, busy, overrun out)
//
// Parameters:
//   DATA_WIDTH : sample / average width
//   LOG2_DEPTH : window depth is 2^LOG2_DEPTH samples (>= 1)
//
// Build option:
//   MOVING_AVG_ROUND_EN : when defined, round half up instead of truncating.
// ----------------------------------------------------------------------------
module moving_avg_window #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_DEPTH = 3
) (
    input  logic              clk,
    input  logic              rst,
    moving_avg_window_if.slave bus
);
    localparam int SUM_W  = DATA_WIDTH + LOG2_DEPTH;
    localparam int DEPTH  = 1 << LOG2_DEPTH;
    localparam int ITER_W = $clog2(SUM_W + 1);
    localparam logic [LOG2_DEPTH:0] FULL = {1'b1, {LOG2_DEPTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, UPDATE, SHIFT, DIVIDE} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:0] buffer [DEPTH];
    logic [SUM_W-1:0]      sum;
    logic [LOG2_DEPTH:0]   count;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [DATA_WIDTH-1:0] s_lat;
    logic [DATA_WIDTH-1:0] oldest;

    // Divider: dq holds the not-yet-consumed dividend bits in its top and
    // the quotient bits collected so far in its bottom.
    logic [SUM_W-1:0]      dq;
    logic [LOG2_DEPTH:0]   rem;
    logic [ITER_W-1:0]     div_cnt;

    logic [DATA_WIDTH-1:0] avg_q;
    logic                  avg_valid_q;
    logic                  overrun_q;

    // Combinational helpers
    logic [LOG2_DEPTH:0]   count_inc;
    logic [SUM_W-1:0]      sum_next;
    logic [SUM_W-1:0]      dividend;
    logic [SUM_W-1:0]      sum_shift;
    logic [LOG2_DEPTH+1:0] trial;
    logic                  trial_ge;
    logic [LOG2_DEPTH:0]   rem_next;
    logic [SUM_W-1:0]      dq_next;
    logic                  div_last;

    assign count_inc = (count == FULL) ? count : count + (LOG2_DEPTH + 1)'(1);
    // The oldest entry only leaves the sum once the window is already full.
    assign sum_next  = sum + SUM_W'(s_lat) - ((count == FULL) ? SUM_W'(oldest) : '0);

`ifdef MOVING_AVG_ROUND_EN
    // Adding half the divisor gives round-half-up; the sum headroom from
    // SUM_W covers the extra term.
    assign dividend  = sum_next + SUM_W'(count_inc >> 1);
    assign sum_shift = sum + SUM_W'(DEPTH / 2);
`else
    assign dividend  = sum_next;
    assign sum_shift = sum;
`endif

    assign trial    = {rem, dq[SUM_W-1]};
    assign trial_ge = trial >= {1'b0, count};
    assign rem_next = trial_ge ? (LOG2_DEPTH + 1)'(trial - {1'b0, count})
                               : trial[LOG2_DEPTH:0];
    assign dq_next  = {dq[SUM_W-2:0], trial_ge};
    assign div_last = (div_cnt == ITER_W'(SUM_W - 1));

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is written with non-blocking (<=) so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: state_next takes a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.sample_ready) state_next = UPDATE;
            UPDATE:  state_next = (count_inc == FULL) ? SHIFT : DIVIDE;
            SHIFT:   state_next = IDLE;
            DIVIDE:  if (div_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.busy = (state != IDLE);
    end

    assign bus.avg       = avg_q;
    assign bus.avg_valid = avg_valid_q;
    assign bus.overrun   = overrun_q;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sum         <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            s_lat       <= '0;
            oldest      <= '0;
            dq          <= '0;
            rem         <= '0;
            div_cnt     <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            avg_valid_q <= 1'b0;
            overrun_q   <= bus.sample_ready && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (bus.sample_ready) begin
                        s_lat  <= bus.sample;
                        oldest <= buffer[wr_ptr];
                    end
                end
                UPDATE: begin
                    sum     <= sum_next;
                    count   <= count_inc;
                    wr_ptr  <= wr_ptr + LOG2_DEPTH'(1);
                    dq      <= dividend;
                    rem     <= '0;
                    div_cnt <= '0;
                end
                SHIFT: begin
                    avg_q       <= DATA_WIDTH'(sum_shift >> LOG2_DEPTH);
                    avg_valid_q <= 1'b1;
                end
                DIVIDE: begin
                    dq      <= dq_next;
                    rem     <= rem_next;
                    div_cnt <= div_cnt + ITER_W'(1);
                    if (div_last) begin
                        avg_q       <= DATA_WIDTH'(dq_next);
                        avg_valid_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the sample buffer has no reset; entries are only read once count
    // shows they were written since the last reset.
    always_ff @(posedge clk) begin
        if (!rst && state == UPDATE) buffer[wr_ptr] <= s_lat;
    end
endmodule
